// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a contiguous ROM/RAM address range and streams
// the returned words as valid/ready beats with a last marker.
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic                  i_abort,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int DEPTH = RD_LATENCY + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           issued_q;
    logic [LW-1:0]           beat_q;
    logic                    done_q, done_d;
    logic [RD_LATENCY-1:0]   tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   fifo_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           inflight;

    logic credit;
    logic start_ok;
    logic start_zero;
    logic abort_act;
    logic push;
    logic fire;
    logic last_issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Credit counts reads still in the tag pipe; a concurrent pop earns none.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(tag_q[i]);
        end
    end

    assign credit     = ({1'b0, cnt_q} + {1'b0, inflight}) < DEPTH_C;
    assign start_ok   = (state_q == S_IDLE) && i_start && (i_len != '0);
    assign start_zero = (state_q == S_IDLE) && i_start && (i_len == '0);
    assign abort_act  = i_abort && (state_q != S_IDLE);
    assign push       = tag_q[RD_LATENCY-1];
    assign fire       = o_valid && i_ready;
    assign last_issue = o_mem_re && (issued_q == len_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (i_abort)         state_d = S_IDLE;
                else if (last_issue) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_abort)              state_d = S_IDLE;
                else if (fire && o_last)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state_q != S_IDLE);
        o_mem_re   = (state_q == S_ISSUE) && credit && !i_abort;
        o_mem_addr = o_mem_re ? base_q + issued_q[ADDR_WIDTH-1:0] : '0;
        o_valid    = (cnt_q != '0);
        o_data     = o_valid ? fifo_q[rd_ptr_q] : '0;
        o_last     = o_valid && (beat_q == len_q - 1'b1);
        o_done     = done_q;
    end

    assign done_d = start_zero
                 || ((state_q == S_DRAIN) && !i_abort && fire && o_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            if (start_ok) begin
                base_q   <= i_base_addr;
                len_q    <= i_len;
                issued_q <= '0;
                beat_q   <= '0;
            end else begin
                if (o_mem_re) issued_q <= issued_q + 1'b1;
                if (fire)     beat_q   <= beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        tag_d    = '0;
        tag_d[0] = o_mem_re;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign cnt_d = cnt_q + CW'(push) - CW'(fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (abort_act) begin
            tag_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= i_mem_rd_data;
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: one instance at read latency 1,
// one at latency 3, both fed from the same command stimulus.
module tb_rom_stream_reader;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base  = '0;
    logic [8:0] len   = '0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;

    logic [7:0]  addr1, addr3;
    logic        re1, re3;
    logic [31:0] rd1, rd3, d1, d3;
    logic        v1, v3, l1, l3, b1, b3, dn1, dn3;

    always #5 clk = ~clk;

    rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base),
        .i_len(len), .i_abort(abort), .o_mem_addr(addr1), .o_mem_re(re1),
        .i_mem_rd_data(rd1), .o_data(d1), .o_valid(v1), .i_ready(ready),
        .o_last(l1), .o_busy(b1), .o_done(dn1)
    );

    rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base),
        .i_len(len), .i_abort(abort), .o_mem_addr(addr3), .o_mem_re(re3),
        .i_mem_rd_data(rd3), .o_data(d3), .o_valid(v3), .i_ready(ready),
        .o_last(l3), .o_busy(b3), .o_done(dn3)
    );

    // Memory models: mem[a] = a*3, garbage when no read was issued.
    logic [31:0] mem [256];
    logic [31:0] m1_q;
    logic [31:0] m3_q [3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i * 3;
    end

    always @(posedge clk) begin
        m1_q    <= re1 ? mem[addr1] : 32'hDEADBEEF;
        m3_q[0] <= re3 ? mem[addr3] : 32'hDEADBEEF;
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end

    assign rd1 = m1_q;
    assign rd3 = m3_q[2];

    function automatic logic [31:0] ev(input int a);
        return (a & 255) * 3;
    endfunction

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] q1 [$];
    logic [32:0] q3 [$];
    logic [7:0]  a1 [$];
    int          qc1 [$];
    int          rc1 [$];
    int          dc1 [$];
    int          bc1 [$];
    logic        st1 = 1'b0, st3 = 1'b0;
    logic [32:0] h1, h3;

    always @(negedge clk) begin
        if (rst_n) begin
            if (st1) chk("hold1", {30'b0, v1, l1, d1}, {30'b0, 1'b1, h1});
            if (st3) chk("hold3", {30'b0, v3, l3, d3}, {30'b0, 1'b1, h3});
            if (v1 && ready) begin
                q1.push_back({l1, d1});
                qc1.push_back(cyc);
            end
            if (v3 && ready) q3.push_back({l3, d3});
            if (re1) begin
                a1.push_back(addr1);
                rc1.push_back(cyc);
            end
            if (dn1) dc1.push_back(cyc);
            if (b1)  bc1.push_back(cyc);
        end
        st1 <= rst_n && v1 && !ready && !abort;
        st3 <= rst_n && v3 && !ready && !abort;
        h1  <= {l1, d1};
        h3  <= {l3, d3};
    end

    int s = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q1.delete(); q3.delete(); a1.delete();
        qc1.delete(); rc1.delete(); dc1.delete(); bc1.delete();
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] n);
        start = 1'b1;
        base  = b;
        len   = n;
        step();
        s     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((b1 || b3 || v1 || v3) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) chk("timeout", 1, 0);
        repeat (3) step();
    endtask

    task automatic chk_beats(input string tag, input int b, input int n);
        int bad1 = 0;
        int bad3 = 0;
        logic [32:0] e;
        for (int i = 0; i < q1.size(); i++) begin
            e = {(i == n - 1), ev(b + i)};
            if (q1[i] !== e) bad1++;
        end
        for (int i = 0; i < q3.size(); i++) begin
            e = {(i == n - 1), ev(b + i)};
            if (q3[i] !== e) bad3++;
        end
        chk({tag, "_n1"}, q1.size(), n);
        chk({tag, "_n3"}, q3.size(), n);
        chk({tag, "_beats1"}, bad1, 0);
        chk({tag, "_beats3"}, bad3, 0);
    endtask

    task automatic chk_addr(input string tag, input int b, input int n);
        int bad = 0;
        for (int i = 0; i < a1.size(); i++) begin
            if (a1[i] !== 8'((b + i) & 255)) bad++;
        end
        chk({tag, "_nre"}, a1.size(), n);
        chk({tag, "_addr"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] lf;

        repeat (3) @(negedge clk);
        chk("rst_u1", {19'b0, re1, addr1, v1, d1, l1, b1, dn1}, 64'h0);
        chk("rst_u3", {19'b0, re3, addr3, v3, d3, l3, b3, dn3}, 64'h0);
        #1 rst_n = 1'b1;
        step();

        // Basic: base 0x10, len 4, ready held high
        clr();
        ready = 1'b1;
        do_start(8'h10, 9'd4);
        wait_idle(100);
        chk_beats("basic", 8'h10, 4);
        chk_addr("basic", 8'h10, 4);
        chk("basic_lat", (qc1.size() > 0) ? qc1[0] - s : -1, 2);
        chk("basic_tput", (qc1.size() == 4) ? qc1[3] - qc1[0] : -1, 3);
        chk("basic_re0", (rc1.size() > 0) ? rc1[0] - s : -1, 0);
        chk("basic_nbusy", bc1.size(), 6);
        chk("basic_ndone", dc1.size(), 1);
        chk("basic_done_t", (dc1.size() > 0) ? dc1[0] - s : -1, 6);

        // Address wrap
        clr();
        do_start(8'hFE, 9'd4);
        wait_idle(100);
        chk_beats("wrap", 8'hFE, 4);
        chk_addr("wrap", 8'hFE, 4);

        // Full 256-word range
        clr();
        do_start(8'h00, 9'd256);
        wait_idle(2000);
        chk_beats("full", 0, 256);
        chk_addr("full", 0, 256);
        chk("full_tput", (qc1.size() == 256) ? qc1[255] - qc1[0] : -1, 255);

        // Backpressure with pseudo-random ready and a 10-cycle stall
        clr();
        do_start(8'h20, 9'd16);
        n  = 0;
        lf = 8'h5A;
        while ((b1 || b3 || v1 || v3) && n < 400) begin
            lf    = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            ready = (n >= 10 && n < 20) ? 1'b0 : lf[0];
            step();
            n++;
        end
        chk("bp_timeout", n < 400, 1);
        ready = 1'b1;
        repeat (3) step();
        chk_beats("bp", 8'h20, 16);
        chk("bp_ndone", dc1.size(), 1);

        // Zero length
        clr();
        do_start(8'h33, 9'd0);
        repeat (4) step();
        chk("zero_ndone", dc1.size(), 1);
        chk("zero_done_t", (dc1.size() > 0) ? dc1[0] - s : -1, 0);
        chk("zero_nre", rc1.size(), 0);
        chk("zero_nbeat", q1.size() + q3.size(), 0);
        chk("zero_nbusy", bc1.size(), 0);

        // Start while busy is ignored
        clr();
        do_start(8'h50, 9'd8);
        repeat (2) step();
        do_start(8'h00, 9'd2);
        wait_idle(200);
        chk_beats("busy", 8'h50, 8);
        chk_addr("busy", 8'h50, 8);
        chk("busy_ndone", dc1.size(), 1);

        // Abort with reads in flight while stalled
        clr();
        do_start(8'h60, 9'd8);
        n = 0;
        while (q1.size() < 2 && n < 50) begin
            step();
            n++;
        end
        ready = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_out", {v1, b1, v3, b3}, 4'b0000);
        chk("abort_nbeat", q1.size(), 2);
        clr();
        ready = 1'b1;
        repeat (6) step();
        chk("abort_ndone", dc1.size(), 0);
        chk("abort_stale", q1.size() + q3.size(), 0);
        chk("abort_nbusy", bc1.size(), 0);
        do_start(8'h40, 9'd2);
        wait_idle(100);
        chk_beats("post_abort", 8'h40, 2);

        // Asynchronous reset mid-transfer
        clr();
        do_start(8'h10, 9'd8);
        n = 0;
        while (q1.size() < 3 && n < 50) begin
            step();
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_u1", {19'b0, re1, addr1, v1, d1, l1, b1, dn1}, 64'h0);
        chk("arst_u3", {19'b0, re3, addr3, v3, d3, l3, b3, dn3}, 64'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        clr();
        repeat (4) step();
        chk("arst_ndone", dc1.size(), 0);
        do_start(8'h10, 9'd1);
        wait_idle(100);
        chk_beats("post_rst", 8'h10, 1);
        chk("post_rst_lat", (qc1.size() > 0) ? qc1[0] - s : -1, 2);
        chk("post_rst_ndone", dc1.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
